// File: rtl/sc_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sc_button_conditioner
// Purpose  : Five-key synchronizer/debouncer producing clean active-low levels
//            and one-cycle press-event pulses. Optional auto-repeat on
//            right/left/down, enabled with SC_BUTTONCONDITIONER_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sc_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_GAP      = 2
) (
  input  logic       SC_BUTTONCONDITIONER_CLOCK_50,
  input  logic       SC_BUTTONCONDITIONER_RESET_InHigh,
  input  logic [4:0] SC_BUTTONCONDITIONER_rawButtons_InLow,
  output logic [4:0] SC_BUTTONCONDITIONER_buttons_OutLow,
  output logic [4:0] SC_BUTTONCONDITIONER_pressEvent_Out
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CYCLES);
  localparam bit ONE_CYCLE = (DEBOUNCE_CYCLES == 1);

`ifdef SC_BUTTONCONDITIONER_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int GW = $clog2(REPEAT_GAP + 1);
  localparam logic [HW-1:0] DELAY_C  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] PERIOD_C = HW'(REPEAT_PERIOD);
  localparam logic [GW-1:0] GAP_C    = GW'(REPEAT_GAP);
`endif

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Reject configurations that would break the counters or the repeat gap.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_GAP < 1 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD <= REPEAT_GAP) begin : g_cfg_error
    $error("sc_button_conditioner: illegal parameter combination");
  end

  logic       clk;
  logic       rst;
  logic [4:0] sync_meta;
  logic [4:0] sync_s;
  logic [4:0] btn_level;
  logic [4:0] btn_event;

  assign clk = SC_BUTTONCONDITIONER_CLOCK_50;
  assign rst = SC_BUTTONCONDITIONER_RESET_InHigh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 5'b11111;
      sync_s    <= 5'b11111;
    end else begin
      sync_meta <= SC_BUTTONCONDITIONER_rawButtons_InLow;
      sync_s    <= sync_meta;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_chan
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          level;
    logic          press;

    // Saturating increment: the count can never wrap past the target.
    assign cnt_inc = (cnt == CNT_TARGET) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= RELEASED;
        cnt   <= '0;
        level <= 1'b1;
        press <= 1'b0;
      end else begin
        press <= 1'b0;
        case (state)
          RELEASED: begin
            if (!sync_s[i]) begin
              if (ONE_CYCLE) begin
                state <= PRESSED;
                level <= 1'b0;
                press <= 1'b1;
              end else begin
                state <= PRESS_WAIT;
                cnt   <= CW'(1);
              end
            end
          end
          PRESS_WAIT: begin
            if (sync_s[i]) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt_inc == CNT_TARGET) begin
              state <= PRESSED;
              cnt   <= '0;
              level <= 1'b0;
              press <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          PRESSED: begin
            if (sync_s[i]) begin
              if (ONE_CYCLE) begin
                state <= RELEASED;
                level <= 1'b1;
              end else begin
                state <= RELEASE_WAIT;
                cnt   <= CW'(1);
              end
            end
          end
          RELEASE_WAIT: begin
            if (!sync_s[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt_inc == CNT_TARGET) begin
              state <= RELEASED;
              cnt   <= '0;
              level <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b1;
          end
        endcase
      end
    end

`ifdef SC_BUTTONCONDITIONER_AUTOREPEAT_EN
    if (i >= 2) begin : g_repeat
      logic [HW-1:0] hold;
      logic [HW-1:0] hold_inc;
      logic [HW-1:0] hold_target;
      logic          repeating;
      logic [GW-1:0] gap;
      logic          rep_press;
      logic          held;

      assign held        = (state == PRESSED) || (state == RELEASE_WAIT);
      assign hold_inc    = hold + 1'b1;
      assign hold_target = repeating ? PERIOD_C : DELAY_C;

      // Hold count restarts at each repeat, so later repeats land every PERIOD.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold      <= '0;
          repeating <= 1'b0;
          gap       <= '0;
          rep_press <= 1'b0;
        end else begin
          rep_press <= 1'b0;
          if (!held) begin
            hold      <= '0;
            repeating <= 1'b0;
            gap       <= '0;
          end else begin
            if (gap != '0) begin
              gap <= gap - 1'b1;
              if (gap == GW'(1) && state == PRESSED) begin
                rep_press <= 1'b1;
              end
            end
            if (hold_inc == hold_target) begin
              hold      <= '0;
              repeating <= 1'b1;
              gap       <= GAP_C;
            end else begin
              hold <= hold_inc;
            end
          end
        end
      end

      assign btn_level[i] = level | (gap != '0);
      assign btn_event[i] = press | rep_press;
    end else begin : g_plain
      assign btn_level[i] = level;
      assign btn_event[i] = press;
    end
`else
    assign btn_level[i] = level;
    assign btn_event[i] = press;
`endif
  end

  assign SC_BUTTONCONDITIONER_buttons_OutLow = btn_level;
  assign SC_BUTTONCONDITIONER_pressEvent_Out = btn_event;

endmodule
`default_nettype wire
